// File: rtl/dac_spi_ch_seq.sv
// Multi-channel request sequencer feeding a single SPI DAC: per-channel one-word
// holding slots, round-robin grant, and a tick-paced serialiser with chip-select gap.
//
// state | meaning
// IDLE  | waiting for a full slot; grants by round-robin on the next edge
// FRAME | shifting the granted word out, one phase per tick
// GAP   | chip select held high for CsGap ticks before the next grant
module dac_spi_ch_seq #(
  parameter int WordWidth = 16,
  parameter int NumCh     = 2,
  parameter int DivCnt    = 4,
  parameter int CsGap     = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NumCh-1:0]                         ch_valid,
  output logic [NumCh-1:0]                         ch_ready,
  input  logic [NumCh*WordWidth-1:0]               ch_data,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic [((NumCh > 1) ? $clog2(NumCh) : 1)-1:0] frame_ch,
  output logic                                     dac_cs_n,
  output logic                                     dac_sclk,
  output logic                                     dac_din
);

  localparam int ChW = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int CwW = ChW + 1;
  localparam int PhW = $clog2(2*WordWidth + 2);
  localparam int TkW = $clog2(DivCnt);

  localparam logic [PhW-1:0] PhLast  = PhW'(2*WordWidth + 1);
  localparam logic [PhW-1:0] PhStop  = PhW'(2*WordWidth);
  localparam logic [PhW-1:0] GapLast = PhW'(CsGap - 1);
  localparam logic [TkW-1:0] TkLast  = TkW'(DivCnt - 1);
  localparam logic [CwW-1:0] ChCount = CwW'(NumCh);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  state_t               state;
  logic [WordWidth-1:0] slot [NumCh];
  logic [NumCh-1:0]     slot_full;
  logic [WordWidth-1:0] shreg;
  logic [PhW-1:0]       phase;
  logic [TkW-1:0]       tick_cnt;
  logic [ChW-1:0]       rr_ptr;
  logic [ChW-1:0]       cur_ch;
  logic [ChW-1:0]       gnt_idx;
  logic [ChW-1:0]       gnt_next;
  logic                 gnt_any;
  logic                 tick;

  assign ch_ready = ~slot_full;
  assign tick     = (tick_cnt == TkLast);

  // Search upward from rr_ptr, wrapping at NumCh (which need not be a power of two).
  always_comb begin
    logic [CwW-1:0] s;
    logic [ChW-1:0] idx;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_next = '0;
    s        = '0;
    idx      = '0;
    for (int i = 0; i < NumCh; i++) begin
      s = {1'b0, rr_ptr} + CwW'(i);
      if (s >= ChCount) s = s - ChCount;
      idx = s[ChW-1:0];
      if (!gnt_any && slot_full[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    s = {1'b0, gnt_idx} + CwW'(1);
    if (s >= ChCount) s = '0;
    gnt_next = s[ChW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot_full  <= '0;
      shreg      <= '0;
      phase      <= '0;
      tick_cnt   <= '0;
      rr_ptr     <= '0;
      cur_ch     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_ch   <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_din    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      for (int i = 0; i < NumCh; i++) begin
        if (ch_valid[i] && !slot_full[i]) begin
          slot[i]      <= ch_data[i*WordWidth +: WordWidth];
          slot_full[i] <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (gnt_any) begin
            shreg              <= slot[gnt_idx];
            slot_full[gnt_idx] <= 1'b0;
            cur_ch             <= gnt_idx;
            rr_ptr             <= gnt_next;
            tick_cnt           <= '0;
            phase              <= '0;
            busy               <= 1'b1;
            state              <= FRAME;
          end
        end
        FRAME: begin
          if (tick) begin
            tick_cnt <= '0;
            phase    <= phase + 1'b1;
            if (phase == PhLast) begin
              dac_sclk   <= 1'b0;
              dac_cs_n   <= 1'b1;
              frame_done <= 1'b1;
              frame_ch   <= cur_ch;
              phase      <= '0;
              state      <= GAP;
            end else if (phase == PhStop) begin
              dac_sclk <= 1'b1;
            end else if (phase[0]) begin
              dac_sclk <= 1'b0;
            end else begin
              // Even phase: present the next bit and raise sclk.
              dac_cs_n <= 1'b0;
              dac_sclk <= 1'b1;
              dac_din  <= shreg[WordWidth-1];
              shreg    <= {shreg[WordWidth-2:0], 1'b0};
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            tick_cnt <= '0;
            if (phase == GapLast) begin
              phase <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              phase <= phase + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_ch_seq.sv
// Bench for dac_spi_ch_seq: a pin-level monitor rebuilds each SPI frame and pops
// the expected channel/word pushed by the stimulus tasks.
module tb_dac_spi_ch_seq;
  localparam int W = 16;
  localparam int N = 2;
  localparam int D = 4;
  localparam int G = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   ch_valid;
  logic [N-1:0]   ch_ready;
  logic [N*W-1:0] ch_data;
  logic           busy;
  logic           frame_done;
  logic [0:0]     frame_ch;
  logic           dac_cs_n;
  logic           dac_sclk;
  logic           dac_din;

  dac_spi_ch_seq #(.WordWidth(W), .NumCh(N), .DivCnt(D), .CsGap(G)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_data(ch_data), .busy(busy), .frame_done(frame_done), .frame_ch(frame_ch),
    .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] dq0[$];
  logic [W-1:0] dq1[$];
  int           cq[$];

  logic         prev_sclk = 1'b0;
  logic         prev_cs   = 1'b1;
  int           nbits     = 0;
  logic [W-1:0] rx_word   = '0;
  int           hi_cnt    = 0;
  bit           gap_armed = 1'b0;
  int           frames_seen = 0;

  // Monitor: samples on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    int           exp_ch;
    logic [W-1:0] exp_w;
    if (prev_cs && !dac_cs_n) begin
      nbits   = 0;
      rx_word = '0;
      if (gap_armed) begin
        total++;
        if (hi_cnt < G*D) begin
          bad++;
          $display("FAIL cs_gap: high for %0d cycles, need >= %0d", hi_cnt, G*D);
        end
      end
    end
    if (prev_sclk && !dac_sclk && !dac_cs_n) begin
      rx_word = {rx_word[W-2:0], dac_din};
      nbits++;
    end
    if (dac_cs_n) hi_cnt++;
    if (frame_done === 1'b1) begin
      frames_seen++;
      total++;
      if (cq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: ch=%0d word=%h", frame_ch, rx_word);
      end else begin
        exp_ch = cq.pop_front();
        if (exp_ch == 0 && dq0.size() > 0) exp_w = dq0.pop_front();
        else if (exp_ch == 1 && dq1.size() > 0) exp_w = dq1.pop_front();
        else exp_w = 'x;
        if (frame_ch !== 1'(exp_ch) || rx_word !== exp_w || nbits != W) begin
          bad++;
          $display("FAIL frame: ch=%0d word=%h bits=%0d, want ch=%0d word=%h bits=%0d",
                   frame_ch, rx_word, nbits, exp_ch, exp_w, W);
        end
      end
      hi_cnt    = 0;
      gap_armed = 1'b1;
    end
    prev_sclk = dac_sclk;
    prev_cs   = dac_cs_n;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    ch_valid = '0;
    @(negedge clk);
    rst       = 1'b0;
    gap_armed = 1'b0;
  endtask

  task automatic write_ch(input int i, input logic [W-1:0] d);
    @(negedge clk);
    ch_data[i*W +: W] = d;
    ch_valid[i]       = 1'b1;
    @(negedge clk);
    ch_valid[i]       = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    while ((busy || cq.size() != 0) && c < 4000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c >= 4000) begin
      bad++;
      $display("FAIL wait_idle: timeout, %0d frames still expected", cq.size());
      cq.delete(); dq0.delete(); dq1.delete();
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    ch_valid = 2'b11;
    ch_data  = '1;
    repeat (3) @(negedge clk);
    total++;
    if ({dac_cs_n, dac_sclk, dac_din, busy, frame_done, frame_ch} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_outputs: cs,sclk,din,busy,done,ch=%b want 100000",
               {dac_cs_n, dac_sclk, dac_din, busy, frame_done, frame_ch});
    end
    total++;
    if (ch_ready !== 2'b11) begin
      bad++;
      $display("FAIL reset_ready: ch_ready=%b want 11", ch_ready);
    end
    ch_valid = '0;
    rst      = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int c = 0;
    apply_reset();
    cq.push_back(0); dq0.push_back(16'hA5C3);
    write_ch(0, 16'hA5C3);
    total++;
    if (ch_ready[0] !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL capture: ready0=%b busy=%b want 0 0", ch_ready[0], busy);
    end
    while (!busy && c < 10) begin @(negedge clk); c++; end
    total++;
    if (c != 1 || ch_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL grant: after %0d cycles ready0=%b, want 1 cycle ready0=1", c, ch_ready[0]);
    end
    c = 0;
    while (dac_cs_n && c < 20) begin @(negedge clk); c++; end
    total++;
    if (c != D) begin
      bad++;
      $display("FAIL cs_fall: %0d cycles after grant, want %0d", c, D);
    end
    while (!frame_done && c < 400) begin @(negedge clk); c++; end
    total++;
    if (c != (2*W+2)*D || dac_cs_n !== 1'b1) begin
      bad++;
      $display("FAIL done_time: %0d cycles cs_n=%b, want %0d cs_n=1", c, dac_cs_n, (2*W+2)*D);
    end
    wait_idle();
    total++;
    if (dac_din !== 1'b1) begin
      bad++;
      $display("FAIL din_hold: din=%b want 1", dac_din);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    cq.push_back(0); cq.push_back(1);
    dq0.push_back(16'h1111); dq1.push_back(16'h2222);
    @(negedge clk);
    ch_data  = {16'h2222, 16'h1111};
    ch_valid = 2'b11;
    @(negedge clk);
    ch_valid = '0;
    wait_idle();
  endtask

  task automatic test_fairness();
    int wr[N];
    int c = 0;
    logic [W-1:0] d;
    apply_reset();
    for (int k = 0; k < 3; k++) begin cq.push_back(0); cq.push_back(1); end
    wr[0] = 0; wr[1] = 0;
    while ((wr[0] < 3 || wr[1] < 3) && c < 4000) begin
      @(negedge clk);
      c++;
      ch_valid = '0;
      for (int i = 0; i < N; i++) begin
        if (ch_ready[i] && wr[i] < 3) begin
          d = W'($urandom);
          ch_data[i*W +: W] = d;
          ch_valid[i]       = 1'b1;
          if (i == 0) dq0.push_back(d); else dq1.push_back(d);
          wr[i]++;
        end
      end
    end
    @(negedge clk);
    ch_valid = '0;
    wait_idle();
  endtask

  task automatic test_backpressure();
    int c = 0;
    apply_reset();
    cq.push_back(0); dq0.push_back(16'h0F0F);
    cq.push_back(0); dq0.push_back(16'h7E81);
    write_ch(0, 16'h0F0F);
    while (!busy && c < 10) begin @(negedge clk); c++; end
    write_ch(0, 16'h7E81);
    total++;
    if (ch_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready: ready0=%b want 0", ch_ready[0]);
    end
    write_ch(0, 16'hBEEF);
    total++;
    if (ch_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold: ready0=%b want 0", ch_ready[0]);
    end
    wait_idle();
  endtask

  task automatic test_reset_midframe();
    int c = 0;
    int seen;
    apply_reset();
    write_ch(0, 16'hAAAA);
    while (!busy && c < 10) begin @(negedge clk); c++; end
    write_ch(1, 16'h5555);
    repeat (44 - 2) @(negedge clk);
    seen = frames_seen;
    rst  = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    gap_armed = 1'b0;
    total++;
    if ({dac_cs_n, dac_sclk, busy} !== 3'b100 || ch_ready !== 2'b11) begin
      bad++;
      $display("FAIL midreset: cs,sclk,busy=%b ready=%b want 100 11",
               {dac_cs_n, dac_sclk, busy}, ch_ready);
    end
    repeat (200) @(negedge clk);
    total++;
    if (frames_seen != seen || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet: frames=%0d busy=%b want %0d 0", frames_seen, busy, seen);
    end
    cq.push_back(1); dq1.push_back(16'h1357);
    write_ch(1, 16'h1357);
    wait_idle();
  endtask

  initial begin
    rst      = 1'b0;
    ch_valid = '0;
    ch_data  = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_reset_midframe();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_ch_seq.md
DAC_SPI_CH_SEQ -- requirements
Module: dac_spi_ch_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- WordWidth, 16, bits per serial frame, range 4..32.
- NumCh, 2, number of independent request channels, range 1..8.
- DivCnt, 4, clk cycles per tick; dac_sclk half-period equals DivCnt clk; range 2..64.
- CsGap, 2, minimum ticks that dac_cs_n stays high between frames, range 1..15.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- ch_valid, in, NumCh, per-channel write request.
- ch_ready, out, NumCh, per-channel holding slot empty.
- ch_data, in, NumCh*WordWidth, channel i word at [i*WordWidth +: WordWidth].
- busy, out, 1, a frame or inter-frame gap is in progress.
- frame_done, out, 1, one-cycle pulse at end of each frame.
- frame_ch, out, $clog2(NumCh) (min 1), channel of the most recent frame, valid with frame_done and held afterwards.
- dac_cs_n, out, 1, DAC chip select, active low.
- dac_sclk, out, 1, serial clock, idle low.
- dac_din, out, 1, serial data, MSB first.
REQ-003 All outputs SHALL be registered except ch_ready, which SHALL be a direct decode of the slot-full flags.

Function
REQ-004 Each channel SHALL own a one-word holding slot; ch_ready[i] SHALL equal NOT slot_full[i].
REQ-005 On a clk edge with ch_valid[i] and ch_ready[i] both high, the slot SHALL capture the channel word and set full. ch_valid[i] while the slot is full SHALL be ignored, with no overwrite.
REQ-006 The state machine SHALL have the states IDLE, FRAME and GAP; reset SHALL enter IDLE.
REQ-007 In IDLE with at least one full slot, the block SHALL grant the next cycle-edge channel by round-robin, searching upward from (last granted + 1) mod NumCh; after reset the search SHALL start at channel 0.
REQ-008 On the grant edge the block SHALL copy the slot into the shift register, clear the slot's full flag, record the channel, clear the tick counter and enter FRAME. A slot freed this way SHALL show ch_ready high on the following cycle.
REQ-009 In FRAME and GAP a tick SHALL occur every DivCnt clk cycles; the first tick SHALL occur DivCnt cycles after the grant edge.
REQ-010 Phase counter p (0..2*WordWidth+1) SHALL advance once per tick, with these actions at tick p:
- p=0: dac_cs_n=0, dac_din=word MSB, dac_sclk=1.
- p odd (<2*WordWidth): dac_sclk=0; this is the falling edge at which the DAC samples.
- p=2k (1<=k<WordWidth): dac_din=word bit [WordWidth-1-k], dac_sclk=1.
- p=2*WordWidth: dac_sclk=1.
- p=2*WordWidth+1: dac_sclk=0, dac_cs_n=1, frame_done=1 for one cycle, frame_ch updated, then enter GAP.
REQ-011 GAP SHALL hold dac_cs_n=1 and dac_sclk=0 for CsGap ticks, then enter IDLE. busy SHALL be high in FRAME and GAP.
REQ-012 Total time from grant edge to frame_done SHALL be (2*WordWidth+2)*DivCnt clk cycles.
REQ-013 Slots SHALL keep accepting writes during FRAME and GAP, including a write to the channel currently being transmitted.
REQ-014 dac_din SHALL hold its last value between frames.

Reset
REQ-015 When rst is high at a clk edge, the block SHALL set, regardless of state (including mid-frame): dac_cs_n=1, dac_sclk=0, dac_din=0, frame_done=0, frame_ch=0, busy=0, all slots empty, tick and phase counters 0, round-robin pointer 0, state IDLE.
REQ-016 While rst is high, inputs SHALL be ignored.

Verification (WordWidth=16, NumCh=2, DivCnt=4, CsGap=2)
REQ-017 Single write: ch_data[15:0]=16'hA5C3 with ch_valid[0] for one cycle gives:
- grant on the next edge; dac_cs_n falls 4 cycles after the grant.
- exactly 16 sclk falling edges, with din at those edges = 1010_0101_1100_0011.
- dac_cs_n rises and frame_done pulses 136 cycles after the grant, with frame_ch=0.
REQ-018 Simultaneous requests: ch0=16'h1111 and ch1=16'h2222 in the same cycle gives:
- ch0 frame first, then ch1.
- dac_cs_n high for at least 8 cycles between the frames.
- two frame_done pulses with frame_ch 0 then 1.
REQ-019 Fairness: with both channels re-requested continuously, the frames SHALL alternate 0,1,0,1; there SHALL be no consecutive frames on the same channel while the other channel is pending.
REQ-020 Backpressure: a second ch_valid[0] with value 16'hBEEF while slot 0 is full SHALL be dropped, with ch_ready[0]=0. The next ch0 frame SHALL carry the earlier word.
REQ-021 Reset mid-frame: rst pulsed at phase 10 of a frame gives, on the next cycle:
- dac_cs_n=1, dac_sclk=0, busy=0, all ch_ready high.
- no frame_done pulse.
A subsequent write SHALL transmit normally.
